serial_rx_sequencer: RTL
========================

# serial_rx_sequencer

Controller that sequences a serial-in shift register and a parallel holding register to receive start/stop-framed serial words. It detects the start bit, counts data bits into its internal shift stage, validates the stop bit, and transfers the word into a holding register presented to the consumer over a valid/ready handshake. It sits between the raw serial line (`Sin`) and any downstream register or FSM that consumes parallel bytes.

## Interface
- `WIDTH`, 8, data bits per frame; legal range 2..16.
- `Clock`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; `reset`=0 at a rising edge clears all state.
- `Sin`  in  1  serial data line; idle level 1.
- `bit_en`  in  1  one-cycle sample strobe; `Sin` is sampled only on cycles with `bit_en`=1.
- `ready`  in  1  consumer accepts `data` on a cycle with `valid`=1 and `ready`=1.
- `data`  out  WIDTH  holding-register contents; first received bit at `data[0]`.
- `valid`  out  1  `data` holds an unaccepted word.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).
- `frame_err`  out  1  one-cycle pulse: stop bit sampled as 0.
- `overrun`  out  1  sticky: a good frame completed while `valid`=1 and was not accepted.

## Operation
- FSM states: IDLE, DATA, STOP (plus PARITY when `SERIAL_RX_PARITY_EN` is defined). Transitions occur only on cycles with `bit_en`=1.
- IDLE: when `Sin`=0, clear bit counter and go to DATA. When `Sin`=1, stay.
- DATA: shift `Sin` into the MSB of the internal shift stage; existing bits move toward bit 0. After WIDTH samples, the first bit is at bit 0. Counter increments; after the WIDTH-th sample go to STOP (or PARITY).
- STOP, `Sin`=1: good frame; load the holding register from the shift stage and go to IDLE.
- STOP, `Sin`=0: pulse `frame_err`; do not load; go to IDLE. A start bit is not inferred from this sample.
- Handshake: `valid` sets on load. It clears on the cycle after `valid`&`ready`. `data` is stable while `valid`=1 and unaccepted.
- Load with `valid`=1 and `ready`=0: the new word is dropped, `data` is unchanged, and `overrun` is set.
- Load in the same cycle as accept: the new word is loaded, `valid` stays 1, and `overrun` is not set.
- `overrun` clears only on reset.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values: `data`=0, `valid`=0, `busy`=0, `frame_err`=0, `overrun`=0; FSM in IDLE; shift stage and counter 0.
- Reset asserted mid-frame aborts the frame. The partial word is discarded and no flag is raised.
- Latency: `valid` rises on the edge after the clock edge that samples the stop bit (one registered stage).
- `frame_err` is high for exactly one `Clock` cycle, on the cycle after the stop sample.
- `bit_en` held high continuously gives one bit per clock. The minimum frame is WIDTH+2 `bit_en` strobes (WIDTH+3 with parity).
- `bit_en`=0 freezes the FSM, counter and shift stage. The handshake logic keeps operating.

## Configuration
- `SERIAL_RX_PARITY_EN` defined:
  - A PARITY state follows DATA and samples one even-parity bit.
  - Adds output `parity_err` (1 bit, reset 0), a one-cycle pulse when the data bits XOR the parity bit equals 1.
  - On parity error the frame is not loaded. STOP is still sampled, and `frame_err` may also pulse.
- `SERIAL_RX_PARITY_EN` undefined:
  - There is no PARITY state and no `parity_err` port.
  - The frame is start + WIDTH data bits + stop.

## Test plan
- Reset with `reset`=0 for 2 cycles, then `bit_en`=1 each cycle, send start 0, bits 1,0,1,0,0,0,0,1 (first bit first), stop 1 -> `data`=8'h85, `valid`=1 one cycle after the stop sample, `busy`=0.
- Same frame, but the stop bit is 0 -> `frame_err` pulses 1 cycle, `valid` stays 0, `data` stays 8'h00.
- Receive 8'h85 with `ready`=0, then receive 8'h3C -> `data`=8'h85, `overrun`=1. Then assert `ready` -> `valid` clears on the next cycle and `overrun` stays 1.
- Raise `ready` in the exact cycle the second word loads -> first word is accepted, `data`=8'h3C, `valid` stays 1, `overrun`=0.
- Assert `reset`=0 after 4 data bits -> all outputs 0 and FSM in IDLE. A following full frame 8'hA5 is received correctly.
- With `SERIAL_RX_PARITY_EN`, send 8'h85 with parity bit 0 -> `parity_err` pulses and `valid` stays 0. Send it with parity bit 1 -> `valid`=1, `data`=8'h85.

Source files
------------

// File: rtl/serial_rx_sequencer.sv
// serial_rx_sequencer: receives start/stop-framed serial words, sampling Sin
// on bit_en strobes. Each good word goes into a holding register that is
// offered downstream over a valid/ready handshake.
// Optional feature macro: SERIAL_RX_PARITY_EN adds one even-parity bit after
// the data bits and a parity_err pulse output.
module serial_rx_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic             Sin,
  input  logic             bit_en,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
`ifdef SERIAL_RX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, STOP, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             load;
  logic             accept;
`ifdef SERIAL_RX_PARITY_EN
  logic             perr_q, perr_d;        // current frame failed parity
  logic             parity_err_q, parity_err_d;
`endif

  // Next-state logic: frame FSM advances on bit_en; handshake runs every cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    load        = 1'b0;
    accept      = valid_q & ready;
`ifdef SERIAL_RX_PARITY_EN
    perr_d       = perr_q;
    parity_err_d = 1'b0;
`endif

    if (accept) begin
      valid_d = 1'b0;
    end

    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (!Sin) begin
            cnt_d   = '0;
            state_d = DATA;
`ifdef SERIAL_RX_PARITY_EN
            perr_d  = 1'b0;
`endif
          end
        end
        DATA: begin
          // Newest bit enters at the MSB so the first bit ends at bit 0
          shift_d = {Sin, shift_q[WIDTH-1:1]};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          perr_d       = (^shift_q) ^ Sin;
          parity_err_d = perr_d;
          state_d      = STOP;
        end
`endif
        STOP: begin
          state_d = IDLE;
          if (Sin) begin
`ifdef SERIAL_RX_PARITY_EN
            load = ~perr_q;
`else
            load = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A word landing while the previous one is still pending is dropped
    // unless the consumer takes the old word in this very cycle.
    if (load) begin
      if (!valid_q || accept) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      perr_q       <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef SERIAL_RX_PARITY_EN
      perr_q       <= perr_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef SERIAL_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule
